// File: rtl/tlp_wr_axi_master.sv
// Memory Write TLP (4-DW header, single beat) to AXI4 write master: AW, then W, then B.
// Optional error counters (drop_cnt, bresp_err_cnt) enabled by `TLP_WR_AXI_ERR_CNT_EN.
module tlp_wr_axi_master #(
  parameter int DOUBLE_WORD    = 32,
  parameter int HEADER_SIZE    = 4*DOUBLE_WORD,
  parameter int TLP_DATA_WIDTH = 8*DOUBLE_WORD,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [TLP_DATA_WIDTH-1:0]   in_data,
  input  logic [HEADER_SIZE-1:0]      in_hdr,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [TLP_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [TLP_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic                        busy
`ifdef TLP_WR_AXI_ERR_CNT_EN
  ,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 bresp_err_cnt
`endif
);

  localparam int WW = 2*TLP_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_AW, S_W, S_B} state_t;
  state_t r_state, w_state_next;

  logic                      r_in_ready;
  logic [63:5]               r_addr;
  logic [2:0]                r_off;
  logic [3:0]                r_len;
  logic [3:0]                r_fbe, r_lbe;
  logic [TLP_DATA_WIDTH-1:0] r_data;
  logic                      r_two, r_beat;
  logic [WW-1:0]             r_wide, w_wide, w_dmask;
  logic [WW/8-1:0]           r_strb, w_strb;

  logic [9:0] w_len_raw;
  logic       w_legal, w_accept, w_aw_hs, w_w_hs, w_b_hs, w_last_beat;

  assign w_len_raw   = in_hdr[105:96];
  assign w_legal     = (in_hdr[127:120] == 8'b0110_0000) && in_sop && in_eop &&
                       (w_len_raw != 10'd0) && (w_len_raw <= 10'd8) && (in_hdr[67:64] != 4'h0) &&
                       (((w_len_raw == 10'd1) && (in_hdr[71:68] == 4'h0)) ||
                        ((w_len_raw >  10'd1) && (in_hdr[71:68] != 4'h0)));
  assign w_accept    = in_valid && r_in_ready;
  assign w_aw_hs     = (r_state == S_AW) && m_axi_awready;
  assign w_w_hs      = (r_state == S_W) && m_axi_wready;
  assign w_b_hs      = (r_state == S_B) && m_axi_bvalid;
  assign w_last_beat = (r_beat == r_two);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_legal) w_state_next = S_PREP;
      S_PREP: w_state_next = S_AW;
      S_AW:   if (w_aw_hs) w_state_next = S_W;
      S_W:    if (w_w_hs && w_last_beat) w_state_next = S_B;
      S_B:    if (w_b_hs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_beat     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= enable && (w_state_next == S_IDLE) && !w_accept;
      if (r_state == S_PREP)
        r_beat <= 1'b0;
      else if (w_w_hs && !w_last_beat)
        r_beat <= 1'b1;
    end
  end

  // Lane placement over both beats: payload DW i lands on global lane off+i.
  always_comb begin
    w_strb  = '0;
    w_dmask = '0;
    for (int unsigned g = 0; g < 16; g++) begin
      if ((g >= 32'(r_off)) && (g < 32'(r_off) + 32'(r_len))) begin
        w_dmask[32*g +: 32] = '1;
        if (g == 32'(r_off))
          w_strb[4*g +: 4] = r_fbe;
        else if (g == 32'(r_off) + 32'(r_len) - 1)
          w_strb[4*g +: 4] = r_lbe;
        else
          w_strb[4*g +: 4] = 4'hF;
      end
    end
  end

  assign w_wide = ({{TLP_DATA_WIDTH{1'b0}}, r_data} << {r_off, 5'b0}) & w_dmask;

  // S_PREP registers the shifted beats so the barrel shift stays off the W path.
  always_ff @(posedge clk) begin
    if (w_accept && w_legal) begin
      r_addr <= {in_hdr[63:32], in_hdr[31:5]};
      r_off  <= in_hdr[4:2];
      r_len  <= in_hdr[99:96];
      r_fbe  <= in_hdr[67:64];
      r_lbe  <= in_hdr[71:68];
      r_data <= in_data;
      r_two  <= ({1'b0, in_hdr[4:2]} + in_hdr[99:96]) > 4'd8;
    end
    if (r_state == S_PREP) begin
      r_wide <= w_wide;
      r_strb <= w_strb;
    end
  end

  assign in_ready      = r_in_ready;
  assign m_axi_awvalid = (r_state == S_AW);
  assign m_axi_awaddr  = m_axi_awvalid ? AXI_ADDR_WIDTH'({r_addr, 5'b0}) : '0;
  assign m_axi_awlen   = m_axi_awvalid ? {7'b0, r_two} : '0;
  assign m_axi_awsize  = 3'd5;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = (r_state == S_W);
  assign m_axi_wdata   = !m_axi_wvalid ? '0 :
                         (r_beat ? r_wide[WW-1:TLP_DATA_WIDTH] : r_wide[TLP_DATA_WIDTH-1:0]);
  assign m_axi_wstrb   = !m_axi_wvalid ? '0 :
                         (r_beat ? r_strb[WW/8-1:TLP_DATA_WIDTH/8] : r_strb[TLP_DATA_WIDTH/8-1:0]);
  assign m_axi_wlast   = m_axi_wvalid && w_last_beat;
  assign m_axi_bready  = (r_state == S_B);
  assign busy          = (r_state != S_IDLE);

`ifdef TLP_WR_AXI_ERR_CNT_EN
  logic [15:0] r_drop_cnt, r_bresp_err_cnt;
  logic        w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt      <= '0;
      r_bresp_err_cnt <= '0;
    end else begin
      if (w_accept && !w_legal && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_b_hs && (m_axi_bresp != 2'b00) && (r_bresp_err_cnt != 16'hFFFF))
        r_bresp_err_cnt <= r_bresp_err_cnt + 16'd1;
    end
  end

  assign drop_cnt      = r_drop_cnt;
  assign bresp_err_cnt = r_bresp_err_cnt;
  assign w_unused      = ^{in_hdr[119:106], in_hdr[95:72], in_hdr[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{in_hdr[119:106], in_hdr[95:72], in_hdr[1:0], m_axi_bresp};
`endif

endmodule

// File: tb/tb_tlp_wr_axi_master.sv
// Self-checking bench for tlp_wr_axi_master: directed cases plus random TLPs
// against a DW-level reference model; counter checks under `TLP_WR_AXI_ERR_CNT_EN.
module tb_tlp_wr_axi_master;

  logic         clk = 1'b0;
  logic         rst, enable;
  logic [255:0] in_data;
  logic [127:0] in_hdr;
  logic         in_sop, in_eop, in_valid, in_ready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready, busy;
`ifdef TLP_WR_AXI_ERR_CNT_EN
  logic [15:0]  drop_cnt, bresp_err_cnt;
  int           exp_drop = 0, exp_berr = 0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // expected transaction, filled by model()
  logic [63:0]  e_awaddr;
  logic [7:0]   e_awlen;
  int           e_beats;
  logic [255:0] e_wdata [2];
  logic [255:0] e_mask  [2];
  logic [31:0]  e_wstrb [2];

  tlp_wr_axi_master dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_data(in_data), .in_hdr(in_hdr), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .busy(busy)
`ifdef TLP_WR_AXI_ERR_CNT_EN
    , .drop_cnt(drop_cnt), .bresp_err_cnt(bresp_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [7:0] ft, input logic [9:0] len,
                                           input logic [3:0] lbe, input logic [3:0] fbe,
                                           input logic [63:0] addr);
    logic [127:0] h;
    h = '0;
    h[127:120] = ft;
    h[105:96]  = len;
    h[71:68]   = lbe;
    h[67:64]   = fbe;
    h[63:32]   = addr[63:32];
    h[31:2]    = addr[31:2];
    return h;
  endfunction

  function automatic bit is_legal(input logic [127:0] h, input logic sop, input logic eop);
    int len;
    len = int'(h[105:96]);
    if (h[127:120] != 8'h60) return 0;
    if (!(sop && eop)) return 0;
    if (len < 1 || len > 8) return 0;
    if (h[67:64] == 4'h0) return 0;
    if (len == 1) return h[71:68] == 4'h0;
    return h[71:68] != 4'h0;
  endfunction

  // Reference: place each payload DW on global lane off+i of a two-beat window.
  task automatic model(input logic [127:0] h, input logic [255:0] d);
    logic [63:0] addr;
    int len, off, g, b, l;
    addr     = {h[63:2], 2'b00};
    len      = int'(h[105:96]);
    off      = int'(addr[4:2]);
    e_beats  = (off + len > 8) ? 2 : 1;
    e_awaddr = addr & ~64'h1F;
    e_awlen  = 8'(e_beats - 1);
    for (int k = 0; k < 2; k++) begin
      e_wdata[k] = '0; e_mask[k] = '0; e_wstrb[k] = '0;
    end
    for (int i = 0; i < len; i++) begin
      g = off + i; b = g / 8; l = g % 8;
      e_wdata[b][32*l +: 32] = d[32*i +: 32];
      e_mask[b][32*l +: 32]  = '1;
      e_wstrb[b][4*l +: 4]   = (i == 0) ? h[67:64] : ((i == len - 1) ? h[71:68] : 4'hF);
    end
  endtask

  function automatic logic [255:0] rnd_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Present a beat and return in the cycle after it is accepted.
  task automatic present(input logic [127:0] h, input logic [255:0] d, input logic sop, input logic eop);
    int t;
    in_hdr = h; in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 1'(t < 200), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic legal_txn(input logic [127:0] h, input logic [255:0] d, input int aw_dly,
                           input bit wtog, input int b_dly, input logic [1:0] br,
                           input bit hold, input logic [127:0] h2, input logic [255:0] d2,
                           input bit drop_en);
    model(h, d);
    present(h, d, 1'b1, 1'b1);
    if (hold) begin
      in_hdr = h2; in_data = d2; in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
    end
    if (drop_en) enable = 1'b0;
    chk("rdy_drop", in_ready, 1'b0);
    chk("busy_start", busy, 1'b1);
    chk("aw_not_early", m_axi_awvalid, 1'b0);
    @(negedge clk);
    for (int k = 0; k <= aw_dly; k++) begin
      chk("awvalid", m_axi_awvalid, 1'b1);
      chk("no_w_in_aw", m_axi_wvalid, 1'b0);
      chk("awaddr", m_axi_awaddr, e_awaddr);
      chk("awlen", m_axi_awlen, e_awlen);
      chk("rdy_in_aw", in_ready, 1'b0);
      m_axi_awready = (k == aw_dly);
      @(negedge clk);
    end
    m_axi_awready = 1'b0;
    for (int b = 0; b < e_beats; b++) begin
      for (int p = 0; p < (wtog ? 2 : 1); p++) begin
        chk("wvalid", m_axi_wvalid, 1'b1);
        chk("no_aw_in_w", m_axi_awvalid, 1'b0);
        chk("wdata", m_axi_wdata & e_mask[b], e_wdata[b]);
        chk("wstrb", m_axi_wstrb, e_wstrb[b]);
        chk("wlast", m_axi_wlast, 1'(b == e_beats - 1));
        chk("rdy_in_w", in_ready, 1'b0);
        m_axi_wready = !wtog || (p == 1);
        @(negedge clk);
      end
    end
    m_axi_wready = 1'b0;
    for (int k = 0; k <= b_dly; k++) begin
      chk("bready", m_axi_bready, 1'b1);
      chk("no_w_in_b", m_axi_wvalid, 1'b0);
      chk("rdy_in_b", in_ready, 1'b0);
      m_axi_bvalid = (k == b_dly);
      m_axi_bresp  = (k == b_dly) ? br : 2'b00;
      @(negedge clk);
    end
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    chk("busy_end", busy, 1'b0);
    chk("rdy_after_b", in_ready, enable);
`ifdef TLP_WR_AXI_ERR_CNT_EN
    if (br != 2'b00) exp_berr++;
    chk("bresp_err_cnt", bresp_err_cnt, 16'(exp_berr));
`endif
  endtask

  task automatic illegal_txn(input logic [127:0] h, input logic [255:0] d, input logic sop, input logic eop);
    present(h, d, sop, eop);
    chk("ill_rdy_drop", in_ready, 1'b0);
    chk("ill_busy", busy, 1'b0);
    chk("ill_no_aw", m_axi_awvalid, 1'b0);
    @(negedge clk);
    chk("ill_rdy_back", in_ready, 1'b1);
    chk("ill_no_aw2", m_axi_awvalid, 1'b0);
    chk("ill_busy2", busy, 1'b0);
`ifdef TLP_WR_AXI_ERR_CNT_EN
    exp_drop++;
    chk("drop_cnt", drop_cnt, 16'(exp_drop));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 64'h0);
    chk({tag, "_awlen"}, m_axi_awlen, 8'h0);
    chk({tag, "_awsize"}, m_axi_awsize, 3'd5);
    chk({tag, "_awburst"}, m_axi_awburst, 2'b01);
    chk({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
    chk({tag, "_wdata"}, m_axi_wdata, 256'h0);
    chk({tag, "_wstrb"}, m_axi_wstrb, 32'h0);
    chk({tag, "_wlast"}, m_axi_wlast, 1'b0);
    chk({tag, "_wvalid"}, m_axi_wvalid, 1'b0);
    chk({tag, "_bready"}, m_axi_bready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
`ifdef TLP_WR_AXI_ERR_CNT_EN
    chk({tag, "_drop_cnt"}, drop_cnt, 16'h0);
    chk({tag, "_berr_cnt"}, bresp_err_cnt, 16'h0);
`endif
  endtask

  initial begin
    logic [127:0] h, h2;
    logic [255:0] d, d2;
    logic [7:0]   ft;
    logic [9:0]   len;
    logic [3:0]   fbe, lbe;
    logic [63:0]  addr;
    logic         sop, eop;

    rst = 1'b1; enable = 1'b1;
    in_data = '0; in_hdr = '0; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", in_ready, 1'b1);

    // len 1 at offset 1
    d = rnd_data(); d[31:0] = 32'hDEADBEEF;
    legal_txn(mk_hdr(8'h60, 10'd1, 4'h0, 4'hF, 64'h1000_0004), d, 0, 0, 0, 2'b00, 0, '0, '0, 0);
    // full aligned beat
    legal_txn(mk_hdr(8'h60, 10'd8, 4'hF, 4'hF, 64'h20), rnd_data(), 0, 0, 0, 2'b00, 0, '0, '0, 0);
    // 32-byte crossing, two beats
    legal_txn(mk_hdr(8'h60, 10'd4, 4'h3, 4'hC, 64'h3C), rnd_data(), 0, 0, 0, 2'b00, 0, '0, '0, 0);

    // illegal: MRd, len 9, sop without eop
    illegal_txn(mk_hdr(8'h20, 10'd1, 4'h0, 4'hF, 64'h100), rnd_data(), 1'b1, 1'b1);
    illegal_txn(mk_hdr(8'h60, 10'd9, 4'hF, 4'hF, 64'h100), rnd_data(), 1'b1, 1'b1);
    illegal_txn(mk_hdr(8'h60, 10'd2, 4'hF, 4'hF, 64'h100), rnd_data(), 1'b1, 1'b0);

    // backpressure with a second TLP held on the input
    h2 = mk_hdr(8'h60, 10'd6, 4'h7, 4'hE, 64'hABCD_0000_0000_0058); d2 = rnd_data();
    legal_txn(mk_hdr(8'h60, 10'd5, 4'h1, 4'h8, 64'h4_0000_0010), rnd_data(), 5, 1, 10, 2'b10, 1, h2, d2, 0);
    legal_txn(h2, d2, 1, 1, 2, 2'b00, 0, '0, '0, 0);

    // enable dropped mid-transaction: finishes, then no new accept
    legal_txn(mk_hdr(8'h60, 10'd3, 4'hF, 4'hF, 64'h80), rnd_data(), 2, 0, 1, 2'b11, 0, '0, '0, 1);
    h = mk_hdr(8'h60, 10'd2, 4'h9, 4'h6, 64'h1C); d = rnd_data();
    in_hdr = h; in_data = d; in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("dis_rdy", in_ready, 1'b0);
      chk("dis_busy", busy, 1'b0);
    end
    enable = 1'b1;
    legal_txn(h, d, 0, 0, 0, 2'b00, 0, '0, '0, 0);

    // reset during S_W
    h = mk_hdr(8'h60, 10'd7, 4'hF, 4'h1, 64'h2C); d = rnd_data();
    model(h, d);
    present(h, d, 1'b1, 1'b1);
    @(negedge clk);
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    chk("rst_pre_wvalid", m_axi_wvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
`ifdef TLP_WR_AXI_ERR_CNT_EN
    exp_drop = 0; exp_berr = 0;
`endif
    @(negedge clk);
    chk("rdy_after_midrst", in_ready, 1'b1);
    legal_txn(mk_hdr(8'h60, 10'd8, 4'h3, 4'hF, 64'h64), rnd_data(), 0, 0, 0, 2'b00, 0, '0, '0, 0);

    // random mix
    for (int it = 0; it < 40; it++) begin
      ft = 8'h60; sop = 1'b1; eop = 1'b1;
      len  = 10'($urandom_range(1, 8));
      addr = {$urandom, $urandom} & ~64'h3;
      fbe  = 4'($urandom_range(1, 15));
      lbe  = (len == 10'd1) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: ft  = 8'($urandom);
          1: len = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(9, 1023));
          2: fbe = 4'h0;
          3: lbe = (len == 10'd1) ? 4'($urandom_range(1, 15)) : 4'h0;
          4: sop = 1'b0;
          default: eop = 1'b0;
        endcase
      end
      h = mk_hdr(ft, len, lbe, fbe, addr);
      d = rnd_data();
      if (is_legal(h, sop, eop))
        legal_txn(h, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)), 0, '0, '0, 0);
      else
        illegal_txn(h, d, sop, eop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
